// File: rtl/shift_reg_stream.sv
// Double-buffered PISO shift register with a simultaneous SIPO capture path.
// A one-entry holding register feeds the shifter so consecutive words leave with no gap tick.
module shift_reg_stream #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_VAL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] cap_data,
  output logic             cap_valid,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_in;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_cap_data;
  logic             r_cap_valid;

  logic             w_active;
  logic             w_shift;
  logic             w_last;
  logic             w_reload;
  logic             w_accept;
  logic [WIDTH-1:0] w_in_next;
  logic [WIDTH-1:0] w_out_shift;

  assign w_active = (r_cnt != '0);
  assign w_shift  = shift_en && w_active;
  assign w_last   = shift_en && (r_cnt == CNT_ONE);
  // Reload on an idle tick, or on the last-bit tick for back-to-back words.
  assign w_reload = shift_en && r_hold_full && (!w_active || (r_cnt == CNT_ONE));
  assign w_accept = load_valid && !r_hold_full;

  assign w_in_next   = MSB_FIRST ? {r_in[WIDTH-2:0], ser_in} : {ser_in, r_in[WIDTH-1:1]};
  assign w_out_shift = MSB_FIRST ? {r_out[WIDTH-2:0], 1'b0}  : {1'b0, r_out[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_out       <= '0;
      r_in        <= '0;
      r_cnt       <= '0;
      r_cap_data  <= '0;
      r_cap_valid <= 1'b0;
    end else begin
      if (w_accept) r_hold <= load_data;
      if (w_reload)      r_hold_full <= 1'b0;
      else if (w_accept) r_hold_full <= 1'b1;

      r_cap_valid <= w_last;
      if (w_last)  r_cap_data <= w_in_next;
      if (w_shift) r_in       <= w_in_next;

      if (w_reload) begin
        r_out <= r_hold;
        r_cnt <= CNT_FULL;
      end else if (w_shift) begin
        r_cnt <= r_cnt - CNT_ONE;
        if (!w_last) r_out <= w_out_shift;
      end
    end
  end

  assign load_ready = !r_hold_full;
  assign busy       = w_active || r_hold_full;
  assign cap_data   = r_cap_data;
  assign cap_valid  = r_cap_valid;
  assign ser_out    = w_active ? (MSB_FIRST ? r_out[WIDTH-1] : r_out[0]) : IDLE_VAL;

endmodule

// File: tb/tb_shift_reg_stream.sv
// Directed bench for shift_reg_stream: an MSB-first and an LSB-first instance, 8-bit words.
module tb_shift_reg_stream;

  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  logic       sen_a, lv_a, lr_a, si_drv_a, so_a, cv_a, busy_a, loop_a, si_a;
  logic [7:0] ld_a, cd_a;
  logic       sen_b, lv_b, lr_b, si_b, so_b, cv_b, busy_b;
  logic [7:0] ld_b, cd_b;

  assign si_a = loop_a ? so_a : si_drv_a;

  shift_reg_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .shift_en(sen_a), .load_data(ld_a), .load_valid(lv_a),
    .load_ready(lr_a), .ser_in(si_a), .ser_out(so_a), .cap_data(cd_a),
    .cap_valid(cv_a), .busy(busy_a));

  shift_reg_stream #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .shift_en(sen_b), .load_data(ld_b), .load_valid(lv_b),
    .load_ready(lr_b), .ser_in(si_b), .ser_out(so_b), .cap_data(cd_b),
    .cap_valid(cv_b), .busy(busy_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  w8;
  logic [15:0] w16;
  logic        prev;
  int          acc, caps;

  initial begin
    reset = 1'b1;
    sen_a = 0; lv_a = 0; ld_a = '0; si_drv_a = 0; loop_a = 0;
    sen_b = 0; lv_b = 0; ld_b = '0; si_b = 0;
    #12;
    chk("rst_ser_out", 32'(so_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_load_ready", 32'(lr_a), 1);
    chk("rst_cap_valid", 32'(cv_a), 0);
    chk("rst_cap_data", 32'(cd_a), 0);
    reset = 1'b0;

    // idle ticks: nothing moves
    sen_a = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_ser_out", 32'(so_a), 0);
      chk("idle_busy", 32'(busy_a), 0);
      chk("idle_cap_valid", 32'(cv_a), 0);
    end

    // single word A5 with loopback
    sen_a = 0; ld_a = 8'hA5; lv_a = 1;
    step();
    chk("a5_load_ready", 32'(lr_a), 0);
    chk("a5_busy", 32'(busy_a), 1);
    chk("a5_ser_out_pre", 32'(so_a), 0);
    lv_a = 0; loop_a = 1; sen_a = 1; w8 = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("a5_ser_out", 32'(so_a), 32'(w8[8-k]));
      chk("a5_cap_valid", 32'(cv_a), 0);
    end
    step();
    chk("a5_cap_valid9", 32'(cv_a), 1);
    chk("a5_cap_data", 32'(cd_a), 32'h A5);
    chk("a5_ser_out_idle", 32'(so_a), 0);
    chk("a5_busy_end", 32'(busy_a), 0);
    sen_a = 0;
    step();
    chk("a5_cap_pulse", 32'(cv_a), 0);

    // back-to-back 3C then C3
    ld_a = 8'h3C; lv_a = 1;
    step();
    lv_a = 0; sen_a = 1; w16 = 16'h3CC3;
    for (int t = 1; t <= 17; t++) begin
      lv_a = (t == 2); ld_a = 8'hC3;
      step();
      if (t <= 16) chk("b2b_ser_out", 32'(so_a), 32'(w16[16-t]));
      chk("b2b_cap_valid", 32'(cv_a), 32'((t == 9) || (t == 17)));
      if (t == 2) chk("b2b_ready_low", 32'(lr_a), 0);
      if (t == 9) chk("b2b_cap_data0", 32'(cd_a), 32'h3C);
      if (t == 17) chk("b2b_cap_data1", 32'(cd_a), 32'hC3);
    end
    chk("b2b_idle", 32'(so_a), 0);
    lv_a = 0; sen_a = 0;

    // LSB-first instance, ser_in tied high
    si_b = 1; ld_b = 8'h01; lv_b = 1;
    step();
    lv_b = 0; sen_b = 1; w8 = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("lsb_ser_out", 32'(so_b), 32'(w8[k-1]));
    end
    step();
    chk("lsb_cap_valid", 32'(cv_b), 1);
    chk("lsb_cap_data", 32'(cd_b), 32'hFF);
    sen_b = 0;

    // shift_en every 3rd clk, load_valid held
    acc = 0; caps = 0; loop_a = 1; lv_a = 1; ld_a = 8'h5A;
    for (int c = 0; c < 60; c++) begin
      sen_a = (c % 3 == 2);
      if (lr_a) acc++;
      prev = so_a;
      step();
      if (cv_a) begin
        caps++;
        chk("slow_cap_data", 32'(cd_a), 32'h5A);
      end
      if (!sen_a) chk("slow_ser_hold", 32'(so_a), 32'(prev));
    end
    chk("slow_accepts", 32'(acc), 4);
    chk("slow_caps", 32'(caps), 2);
    chk("slow_busy", 32'(busy_a), 1);
    lv_a = 0; sen_a = 0;
    reset = 1;
    #2;
    chk("rst2_busy", 32'(busy_a), 0);
    chk("rst2_cap_data", 32'(cd_a), 0);
    reset = 0;
    step();

    // async reset mid-word
    loop_a = 0; si_drv_a = 0; ld_a = 8'hF0; lv_a = 1;
    step();
    lv_a = 0; sen_a = 1;
    step();
    chk("abort_bit1", 32'(so_a), 1);
    ld_a = 8'h0F; lv_a = 1;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("abort_bits", 32'(so_a), 1);
    end
    chk("abort_ready_low", 32'(lr_a), 0);
    #3 reset = 1;
    #1;
    chk("abort_ser_out", 32'(so_a), 0);
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_ready", 32'(lr_a), 1);
    chk("abort_cap_valid", 32'(cv_a), 0);
    chk("abort_cap_data", 32'(cd_a), 0);
    lv_a = 0;
    #2 reset = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_cap", 32'(cv_a), 0);
      chk("abort_idle", 32'(busy_a), 0);
    end
    sen_a = 0; ld_a = 8'h81; lv_a = 1;
    step();
    lv_a = 0; loop_a = 1; sen_a = 1; w8 = 8'h81;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("post_ser_out", 32'(so_a), 32'(w8[8-k]));
      chk("post_cap_valid", 32'(cv_a), 0);
    end
    step();
    chk("post_cap_valid9", 32'(cv_a), 1);
    chk("post_cap_data", 32'(cd_a), 32'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
